// File: rtl/i2c_input_filter.sv
`timescale 1ns/1ps
// i2c_input_filter: synchronises raw SCL/SDA, rejects spikes shorter than
// filt_len_i synchronised samples, and derives SCL edge, START/STOP pulses
// plus a bus-busy flag. Define I2C_FILTER_GLITCH_CNT_EN to build the
// saturating glitch counter; otherwise glitch_cnt_o is tied to zero.
module i2c_input_filter #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FiltWidth  = 4,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 scl_i,
  input  logic                 sda_i,
  input  logic                 enable_i,
  input  logic [FiltWidth-1:0] filt_len_i,
  input  logic                 glitch_clr_i,
  output logic                 scl_o,
  output logic                 sda_o,
  output logic                 scl_rise_o,
  output logic                 scl_fall_o,
  output logic                 start_o,
  output logic                 stop_o,
  output logic                 bus_busy_o,
  output logic [CntWidth-1:0]  glitch_cnt_o
);

  localparam int unsigned IncWidth = FiltWidth + 1;

  logic [SyncStages-1:0] scl_sync;
  logic [SyncStages-1:0] sda_sync;
  logic [1:0]            line_s;   // [0] = SCL, [1] = SDA
  logic [1:0]            q;
  logic [1:0]            q_d;
  logic [1:0]            glitch;
  logic                  en_d;
  logic                  busy;
  logic                  ev_en;
  logic                  scl_hi_stable;

  // Synchroniser chains, reset to the idle-high bus level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SyncStages-2:0], scl_i};
      sda_sync <= {sda_sync[SyncStages-2:0], sda_i};
    end
  end

  assign line_s = {sda_sync[SyncStages-1], scl_sync[SyncStages-1]};

  for (genvar g = 0; g < 2; g++) begin : g_line
    logic                 q_r;
    logic                 q_n;
    logic                 glitch_n;
    logic [FiltWidth-1:0] cnt_r;
    logic [FiltWidth-1:0] cnt_n;
    logic [FiltWidth:0]   cnt_inc;

    // Stability counter: accept a new level once it has persisted long enough.
    // The >= compare also covers filt_len_i of 0/1 and a length lowered mid-count.
    always_comb begin
      q_n      = q_r;
      cnt_n    = cnt_r;
      glitch_n = 1'b0;
      cnt_inc  = {1'b0, cnt_r} + IncWidth'(1);
      if (!enable_i) begin
        q_n   = 1'b1;
        cnt_n = '0;
      end else if (line_s[g] != q_r) begin
        if (cnt_inc >= {1'b0, filt_len_i}) begin
          q_n   = line_s[g];
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc[FiltWidth-1:0];
        end
      end else if (cnt_r != '0) begin
        cnt_n    = '0;
        glitch_n = 1'b1;
      end
    end

    // Filtered level and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q_r   <= 1'b1;
        cnt_r <= '0;
      end else begin
        q_r   <= q_n;
        cnt_r <= cnt_n;
      end
    end

    assign q[g]      = q_r;
    assign glitch[g] = glitch_n;
  end

  // Delayed copies of the filtered levels and of the enable for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_d  <= 2'b11;
      en_d <= 1'b0;
    end else begin
      q_d  <= q;
      en_d <= enable_i;
    end
  end

  assign ev_en         = enable_i & en_d;
  assign scl_hi_stable = q[0] & q_d[0];

  assign scl_o      = q[0];
  assign sda_o      = q[1];
  assign scl_rise_o = ev_en &  q[0] & ~q_d[0];
  assign scl_fall_o = ev_en & ~q[0] &  q_d[0];
  // SCL must be steady high, so a simultaneous SCL edge masks START/STOP
  assign start_o    = ev_en & scl_hi_stable & ~q[1] &  q_d[1];
  assign stop_o     = ev_en & scl_hi_stable &  q[1] & ~q_d[1];

  // Bus-busy flag: set by START (including repeated START), cleared by STOP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy <= 1'b0;
    end else if (!enable_i) begin
      busy <= 1'b0;
    end else if (start_o) begin
      busy <= 1'b1;
    end else if (stop_o) begin
      busy <= 1'b0;
    end
  end

  assign bus_busy_o = busy;

`ifdef I2C_FILTER_GLITCH_CNT_EN
  localparam int unsigned SumWidth = CntWidth + 1;

  logic [CntWidth-1:0] gcnt;
  logic [CntWidth:0]   gsum;

  always_comb begin
    gsum = {1'b0, gcnt} + SumWidth'(glitch[0]) + SumWidth'(glitch[1]);
  end

  // Saturating glitch counter; clear wins over a same-cycle increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gcnt <= '0;
    end else if (glitch_clr_i) begin
      gcnt <= '0;
    end else if (enable_i) begin
      gcnt <= gsum[CntWidth] ? '1 : gsum[CntWidth-1:0];
    end
  end

  assign glitch_cnt_o = gcnt;
`else
  logic unused_glitch;
  assign unused_glitch = ^{glitch_clr_i, glitch};
  assign glitch_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_i2c_input_filter.sv
`timescale 1ns/1ps
// Randomised and directed bench for i2c_input_filter against a run-length
// reference model of the filter, START/STOP and glitch-count rules.
module tb_i2c_input_filter;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned FiltWidth  = 4;
  localparam int unsigned CntWidth   = 4;
  localparam int          CntMax     = (1 << CntWidth) - 1;
`ifdef I2C_FILTER_GLITCH_CNT_EN
  localparam bit GcntEn = 1'b1;
`else
  localparam bit GcntEn = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 scl;
  logic                 sda;
  logic                 en;
  logic [FiltWidth-1:0] filt_len;
  logic                 glitch_clr;
  logic                 scl_o;
  logic                 sda_o;
  logic                 scl_rise_o;
  logic                 scl_fall_o;
  logic                 start_o;
  logic                 stop_o;
  logic                 bus_busy_o;
  logic [CntWidth-1:0]  glitch_cnt_o;

  i2c_input_filter #(
    .SyncStages(SyncStages),
    .FiltWidth (FiltWidth),
    .CntWidth  (CntWidth)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .scl_i       (scl),
    .sda_i       (sda),
    .enable_i    (en),
    .filt_len_i  (filt_len),
    .glitch_clr_i(glitch_clr),
    .scl_o       (scl_o),
    .sda_o       (sda_o),
    .scl_rise_o  (scl_rise_o),
    .scl_fall_o  (scl_fall_o),
    .start_o     (start_o),
    .stop_o      (stop_o),
    .bus_busy_o  (bus_busy_o),
    .glitch_cnt_o(glitch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each line holds a queue of pending raw samples (the
  // synchroniser delay) and a run length of consecutive samples disagreeing
  // with the accepted level.
  bit sq_scl[$];
  bit sq_sda[$];
  bit m_q[2];
  bit m_qd[2];
  int m_run[2];
  bit m_en_d;
  bit m_busy;
  int m_gcnt;
  bit e_rise, e_fall, e_start, e_stop;

  function automatic void model_reset();
    sq_scl.delete();
    sq_sda.delete();
    for (int i = 0; i < SyncStages; i++) begin
      sq_scl.push_back(1'b1);
      sq_sda.push_back(1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      m_q[i]   = 1'b1;
      m_qd[i]  = 1'b1;
      m_run[i] = 0;
    end
    m_en_d = 1'b0;
    m_busy = 1'b0;
    m_gcnt = 0;
  endfunction

  function automatic void model_eval();
    bit ev;
    bit scl_edge;
    bit sda_edge;
    ev       = en && m_en_d;
    scl_edge = (m_q[0] != m_qd[0]);
    sda_edge = (m_q[1] != m_qd[1]);
    e_rise   = ev && scl_edge && m_q[0];
    e_fall   = ev && scl_edge && !m_q[0];
    e_start  = ev && !scl_edge && m_q[0] && sda_edge && !m_q[1];
    e_stop   = ev && !scl_edge && m_q[0] && sda_edge && m_q[1];
  endfunction

  function automatic void model_step();
    bit s[2];
    int lim;
    int ng;
    model_eval();
    s[0] = sq_scl.pop_front();
    sq_scl.push_back(scl);
    s[1] = sq_sda.pop_front();
    sq_sda.push_back(sda);
    lim = (int'(filt_len) < 1) ? 1 : int'(filt_len);
    ng  = 0;
    for (int i = 0; i < 2; i++) begin
      m_qd[i] = m_q[i];
      if (!en) begin
        m_q[i]   = 1'b1;
        m_run[i] = 0;
      end else if (s[i] != m_q[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= lim) begin
          m_q[i]   = s[i];
          m_run[i] = 0;
        end
      end else if (m_run[i] > 0) begin
        ng++;
        m_run[i] = 0;
      end
    end
    if (!en)          m_busy = 1'b0;
    else if (e_start) m_busy = 1'b1;
    else if (e_stop)  m_busy = 1'b0;
    if (GcntEn) begin
      if (glitch_clr) m_gcnt = 0;
      else if (en)    m_gcnt = (m_gcnt + ng > CntMax) ? CntMax : m_gcnt + ng;
    end
    m_en_d = en;
  endfunction

  task automatic check_outputs();
    model_eval();
    check("scl_o",     scl_o,        m_q[0]);
    check("sda_o",     sda_o,        m_q[1]);
    check("scl_rise",  scl_rise_o,   e_rise);
    check("scl_fall",  scl_fall_o,   e_fall);
    check("start",     start_o,      e_start);
    check("stop",      stop_o,       e_stop);
    check("bus_busy",  bus_busy_o,   m_busy);
    check("glitch_cnt", glitch_cnt_o, m_gcnt);
  endtask

  int obs_start, obs_stop, obs_rise, obs_fall, obs_sda_low;

  task automatic obs_clear();
    obs_start = 0; obs_stop = 0; obs_rise = 0; obs_fall = 0; obs_sda_low = 0;
  endtask

  // One clock cycle: drive after negedge, compare before the edge, step model
  // on the edge, then record pulses just after it.
  task automatic drive(input bit s, input bit d, input bit e, input int l, input bit c);
    @(negedge clk);
    scl        = s;
    sda        = d;
    en         = e;
    filt_len   = FiltWidth'(l);
    glitch_clr = c;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
    obs_start   += int'(start_o);
    obs_stop    += int'(stop_o);
    obs_rise    += int'(scl_rise_o);
    obs_fall    += int'(scl_fall_o);
    obs_sda_low += int'(!sda_o);
  endtask

  task automatic run(input int n, input bit s, input bit d, input bit e, input int l, input bit c);
    for (int i = 0; i < n; i++) drive(s, d, e, l, c);
  endtask

  initial begin
    int fall_at;
    int scl_left, sda_left, dis_left, l;
    bit rs, rd;

    rst_n = 1'b0; scl = 1'b1; sda = 1'b1; en = 1'b0; filt_len = 4; glitch_clr = 1'b0;
    model_reset();
    obs_clear();
    #12;
    check("rst_scl_o",  scl_o,        1);
    check("rst_sda_o",  sda_o,        1);
    check("rst_pulses", {scl_rise_o, scl_fall_o, start_o, stop_o}, 0);
    check("rst_busy",   bus_busy_o,   0);
    check("rst_gcnt",   glitch_cnt_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run(20, 1, 1, 1, 4, 0);

    // 3-sample SDA spike is rejected and counted
    obs_clear();
    run(3, 1, 0, 1, 4, 0);
    run(10, 1, 1, 1, 4, 0);
    check("spike3_sda_low", obs_sda_low, 0);
    check("spike3_gcnt", glitch_cnt_o, GcntEn ? 1 : 0);

    // 4-sample SDA pulse is accepted 2+L edges after the raw change
    fall_at = 0;
    for (int k = 1; k <= 14; k++) begin
      drive(1, (k <= 4) ? 1'b0 : 1'b1, 1, 4, 0);
      if (fall_at == 0 && sda_o == 1'b0) fall_at = k;
    end
    check("pulse4_fall_at", fall_at, 6);
    run(10, 1, 1, 1, 4, 0);

    // START, then reset mid-count while busy
    obs_clear();
    run(10, 1, 0, 1, 2, 0);
    check("start_count", obs_start, 1);
    check("start_busy", bus_busy_o, 1);
    run(3, 1, 1, 1, 2, 0);
    check("pre_rst_busy", bus_busy_o, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_scl_o",  scl_o,        1);
    check("arst_sda_o",  sda_o,        1);
    check("arst_pulses", {scl_rise_o, scl_fall_o, start_o, stop_o}, 0);
    check("arst_busy",   bus_busy_o,   0);
    check("arst_gcnt",   glitch_cnt_o, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(10, 1, 1, 1, 2, 0);

    // Clean START / STOP pair
    obs_clear();
    run(10, 1, 0, 1, 2, 0);
    check("start2_count", obs_start, 1);
    check("start2_busy", bus_busy_o, 1);
    obs_clear();
    run(10, 1, 1, 1, 2, 0);
    check("stop_count", obs_stop, 1);
    check("stop_busy", bus_busy_o, 0);

    // Simultaneous SCL/SDA fall: SCL edge only
    obs_clear();
    run(10, 0, 0, 1, 2, 0);
    check("simul_fall", obs_fall, 1);
    check("simul_start", obs_start, 0);
    obs_clear();
    run(10, 1, 1, 1, 2, 0);
    check("simul_rise", obs_rise, 1);
    check("simul_stop", obs_stop, 0);

    // Disable while busy
    run(10, 1, 0, 1, 2, 0);
    check("dis_pre_busy", bus_busy_o, 1);
    run(3, 1, 0, 0, 2, 0);
    check("dis_busy", bus_busy_o, 0);
    run(10, 1, 0, 1, 2, 0);
    run(10, 1, 1, 1, 2, 0);

    // Glitch counter saturation and clear precedence
    run(1, 1, 1, 1, 4, 1);
    run(3, 1, 1, 1, 4, 0);
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 1, 4, 0);
      run(6, 1, 1, 1, 4, 0);
    end
    check("gcnt_near_max", glitch_cnt_o, GcntEn ? CntMax - 1 : 0);
    drive(0, 0, 1, 4, 0);
    run(6, 1, 1, 1, 4, 0);
    check("gcnt_sat", glitch_cnt_o, GcntEn ? CntMax : 0);
    drive(0, 0, 1, 4, 0);
    run(6, 1, 1, 1, 4, 0);
    check("gcnt_hold", glitch_cnt_o, GcntEn ? CntMax : 0);
    drive(0, 0, 1, 4, 0);
    drive(1, 1, 1, 4, 0);
    drive(1, 1, 1, 4, 0);
    drive(1, 1, 1, 4, 1);
    run(3, 1, 1, 1, 4, 0);
    check("gcnt_clr", glitch_cnt_o, 0);

    // Randomised traffic with varying filter length, disables and clears
    scl_left = 0; sda_left = 0; dis_left = 0; l = 2; rs = 1'b1; rd = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      if (k % 40 == 0) l = int'($urandom_range(0, 6));
      if (scl_left == 0) begin
        rs = ~rs;
        scl_left = int'($urandom_range(1, 10));
      end
      scl_left--;
      if (sda_left == 0) begin
        rd = ~rd;
        sda_left = int'($urandom_range(1, 12));
      end
      sda_left--;
      if (dis_left > 0) dis_left--;
      else if ($urandom_range(0, 99) == 0) dis_left = int'($urandom_range(1, 4));
      drive(rs, rd, dis_left == 0, l, ($urandom_range(0, 99) < 2) && (dis_left == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
